// File: rtl/lsu_dcache_arb.sv
// lsu_dcache_arb: arbitrates the DCache request port between the
// speculative issue queue (port 0) and the committed-store drain (port 1).
module lsu_dcache_arb #(
    parameter int REQ_W      = 128,
    parameter int RSP_W      = 64,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             iq_valid_i,
    output logic             iq_ready_o,
    input  logic [REQ_W-1:0] iq_req_i,
    input  logic             sb_valid_i,
    output logic             sb_ready_o,
    input  logic [REQ_W-1:0] sb_req_i,
    input  logic             sb_urgent_i,
    output logic             dc_valid_o,
    input  logic             dc_ready_i,
    output logic [REQ_W-1:0] dc_req_o,
    input  logic             dc_rvalid_i,
    output logic             dc_rready_o,
    input  logic [RSP_W-1:0] dc_rsp_i,
    output logic             iq_rvalid_o,
    input  logic             iq_rready_i,
    output logic             sb_rvalid_o,
    input  logic             sb_rready_i,
    output logic [RSP_W-1:0] rsp_o,
    output logic             busy_o
);

    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW:0]   MAX_C = (CW + 1)'(MAX_OUT);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

    logic               stage_v_q, stage_v_d;
    logic               stage_src_q, stage_src_d;
    logic [REQ_W-1:0]   stage_pl_q, stage_pl_d;
    logic [MAX_OUT-1:0] tag_src_q, tag_src_d;
    logic [MAX_OUT-1:0] tag_kill_q, tag_kill_d;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      starve_q, starve_d;

    logic          handoff, pop, can_load, credit_ok;
    logic          sb_win, sb_gnt, iq_gnt;
    logic          tag_empty, head_src, head_kill;
    logic [CW:0]   cnt_nxt;

    assign handoff   = stage_v_q && dc_ready_i;
    assign tag_empty = (cnt_q == '0);
    assign head_src  = tag_src_q[rptr_q];
    assign head_kill = tag_kill_q[rptr_q];
    assign pop       = dc_rvalid_i && dc_rready_o;

    assign can_load  = !stage_v_q || dc_ready_i;
    assign cnt_nxt   = {1'b0, cnt_q} + (CW + 1)'(handoff) - (CW + 1)'(pop);
    assign credit_ok = cnt_nxt < MAX_C;

    assign sb_win = sb_valid_i &&
                    (sb_urgent_i || starve_q == S_MAX || !iq_valid_i);
    assign sb_gnt = can_load && credit_ok && sb_win;
    assign iq_gnt = can_load && credit_ok && !sb_win &&
                    iq_valid_i && !flush;

    assign iq_ready_o = iq_gnt;
    assign sb_ready_o = sb_gnt;
    assign dc_valid_o = stage_v_q;
    assign dc_req_o   = stage_pl_q;
    assign rsp_o      = dc_rsp_i;
    assign busy_o     = stage_v_q || !tag_empty;

    // Route the in-order response to the requester named by the head tag.
    always_comb begin
        iq_rvalid_o = 1'b0;
        sb_rvalid_o = 1'b0;
        dc_rready_o = 1'b0;
        if (!tag_empty) begin
            if (head_kill) begin
                dc_rready_o = 1'b1;
            end else if (head_src) begin
                sb_rvalid_o = dc_rvalid_i;
                dc_rready_o = sb_rready_i;
            end else begin
                iq_rvalid_o = dc_rvalid_i;
                dc_rready_o = iq_rready_i;
            end
        end
    end

    // Output stage: load winner, drain on handoff, drop squashed loads.
    always_comb begin
        stage_v_d   = stage_v_q;
        stage_src_d = stage_src_q;
        stage_pl_d  = stage_pl_q;
        if (sb_gnt) begin
            stage_v_d   = 1'b1;
            stage_src_d = 1'b1;
            stage_pl_d  = sb_req_i;
        end else if (iq_gnt) begin
            stage_v_d   = 1'b1;
            stage_src_d = 1'b0;
            stage_pl_d  = iq_req_i;
        end else if (handoff) begin
            stage_v_d = 1'b0;
        end else if (flush && !stage_src_q) begin
            stage_v_d = 1'b0;
        end
    end

    // Tag FIFO: push source on handoff, kill port-0 tags on flush.
    always_comb begin
        tag_src_d  = tag_src_q;
        tag_kill_d = tag_kill_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_nxt[CW-1:0];
        if (flush) begin
            tag_kill_d = tag_kill_q | ~tag_src_q;
        end
        if (handoff) begin
            tag_src_d[wptr_q]  = stage_src_q;
            tag_kill_d[wptr_q] = flush && !stage_src_q;
            wptr_d             = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Count cycles a waiting store has lost arbitration.
    always_comb begin
        starve_d = starve_q;
        if (sb_gnt || !sb_valid_i) begin
            starve_d = '0;
        end else if (starve_q != S_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_v_q   <= 1'b0;
            stage_src_q <= 1'b0;
            stage_pl_q  <= '0;
            tag_src_q   <= '0;
            tag_kill_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
        end else begin
            stage_v_q   <= stage_v_d;
            stage_src_q <= stage_src_d;
            stage_pl_q  <= stage_pl_d;
            tag_src_q   <= tag_src_d;
            tag_kill_q  <= tag_kill_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
        end
    end

    // A response with nothing outstanding means the DCache lost order.
    rsp_without_req: assert property (
        @(posedge clk) disable iff (!rst_n) dc_rvalid_i |-> !tag_empty
    );

endmodule

// File: tb/tb_lsu_dcache_arb.sv
// tb_lsu_dcache_arb: directed and random scenarios against a
// queue-based reference model of the DCache arbiter.
module tb_lsu_dcache_arb;

    localparam int REQ_W      = 128;
    localparam int RSP_W      = 64;
    localparam int MAX_OUT    = 4;
    localparam int STARVE_MAX = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             iq_valid_i = 1'b0;
    logic             iq_ready_o;
    logic [REQ_W-1:0] iq_req_i = '0;
    logic             sb_valid_i = 1'b0;
    logic             sb_ready_o;
    logic [REQ_W-1:0] sb_req_i = '0;
    logic             sb_urgent_i = 1'b0;
    logic             dc_valid_o;
    logic             dc_ready_i = 1'b0;
    logic [REQ_W-1:0] dc_req_o;
    logic             dc_rvalid_i = 1'b0;
    logic             dc_rready_o;
    logic [RSP_W-1:0] dc_rsp_i = '0;
    logic             iq_rvalid_o;
    logic             iq_rready_i = 1'b0;
    logic             sb_rvalid_o;
    logic             sb_rready_i = 1'b0;
    logic [RSP_W-1:0] rsp_o;
    logic             busy_o;

    always #5 clk = ~clk;

    lsu_dcache_arb #(
        .REQ_W(REQ_W), .RSP_W(RSP_W),
        .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .iq_valid_i(iq_valid_i), .iq_ready_o(iq_ready_o),
        .iq_req_i(iq_req_i),
        .sb_valid_i(sb_valid_i), .sb_ready_o(sb_ready_o),
        .sb_req_i(sb_req_i), .sb_urgent_i(sb_urgent_i),
        .dc_valid_o(dc_valid_o), .dc_ready_i(dc_ready_i),
        .dc_req_o(dc_req_o),
        .dc_rvalid_i(dc_rvalid_i), .dc_rready_o(dc_rready_o),
        .dc_rsp_i(dc_rsp_i),
        .iq_rvalid_o(iq_rvalid_o), .iq_rready_i(iq_rready_i),
        .sb_rvalid_o(sb_rvalid_o), .sb_rready_i(sb_rready_i),
        .rsp_o(rsp_o), .busy_o(busy_o)
    );

    // Reference model: one staged request plus a queue of outstanding tags.
    typedef struct {
        bit src;
        bit kill;
    } tag_t;

    tag_t             tq[$];
    bit               m_stv = 0;
    bit               m_src = 0;
    logic [REQ_W-1:0] m_pl = '0;
    int               m_starve = 0;
    bit e_iqr, e_sbr, e_ivr, e_svr, e_rr, e_push, e_pop;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [REQ_W-1:0] rnd_req();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_comb();
        int  after;
        bit  sb_pri;
        e_push = m_stv && dc_ready_i;
        e_ivr = 0;
        e_svr = 0;
        e_rr = 0;
        if (tq.size() != 0) begin
            if (tq[0].kill) begin
                e_rr = 1;
            end else if (!tq[0].src) begin
                e_ivr = dc_rvalid_i;
                e_rr = iq_rready_i;
            end else begin
                e_svr = dc_rvalid_i;
                e_rr = sb_rready_i;
            end
        end
        e_pop = dc_rvalid_i && e_rr;
        after = tq.size() + int'(e_push) - int'(e_pop);
        sb_pri = sb_valid_i &&
                 (sb_urgent_i || m_starve == STARVE_MAX || !iq_valid_i);
        e_sbr = (!m_stv || dc_ready_i) && after < MAX_OUT && sb_pri;
        e_iqr = (!m_stv || dc_ready_i) && after < MAX_OUT && !sb_pri &&
                iq_valid_i && !flush;
    endtask

    task automatic model_tick();
        tag_t t;
        if (!rst_n) begin
            tq.delete();
            m_stv = 0;
            m_starve = 0;
            return;
        end
        if (e_pop) void'(tq.pop_front());
        if (flush) foreach (tq[i]) if (!tq[i].src) tq[i].kill = 1;
        if (e_push) begin
            t.src = m_src;
            t.kill = flush && !m_src;
            tq.push_back(t);
        end
        if (e_sbr || !sb_valid_i) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (e_sbr) begin
            m_stv = 1; m_src = 1; m_pl = sb_req_i;
        end else if (e_iqr) begin
            m_stv = 1; m_src = 0; m_pl = iq_req_i;
        end else if (e_push) begin
            m_stv = 0;
        end else if (flush && !m_src) begin
            m_stv = 0;
        end
    endtask

    function automatic logic [6:0] obs_v();
        return {dc_valid_o, iq_ready_o, sb_ready_o, dc_rready_o,
                iq_rvalid_o, sb_rvalid_o, busy_o};
    endfunction

    function automatic logic [6:0] exp_v();
        return {m_stv, e_iqr, e_sbr, e_rr, e_ivr, e_svr,
                m_stv || tq.size() != 0};
    endfunction

    task automatic settle();
        @(negedge clk);
        model_comb();
    endtask

    task automatic edge_();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; iq_valid_i = 0; sb_valid_i = 0; sb_urgent_i = 0;
        dc_ready_i = 0; dc_rvalid_i = 0; iq_rready_i = 0; sb_rready_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        settle(); edge_();
        settle(); edge_();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        settle(); edge_();
        settle();
        n_cmp++;
        if ({dc_valid_o, busy_o, iq_rvalid_o, sb_rvalid_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {dc_valid_o, busy_o, iq_rvalid_o, sb_rvalid_o});
        end
        n_cmp++;
        if (obs_v() !== exp_v()) begin
            n_bad++;
            $display("FAIL reset_model got=%b want=%b", obs_v(), exp_v());
        end
        edge_();
        rst_n = 1;
    endtask

    task automatic test_starve();
        int streak = 0;
        int sb_wins = 0;
        do_reset();
        iq_valid_i = 1; sb_valid_i = 1; dc_ready_i = 1;
        iq_rready_i = 1; sb_rready_i = 1;
        for (int c = 0; c < 27; c++) begin
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            dc_rvalid_i = tq.size() > 0;
            dc_rsp_i = {$urandom, $urandom};
            settle();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL starve_model c%0d got=%b want=%b",
                         c, obs_v(), exp_v());
            end
            if (sb_ready_o === 1'b1) begin
                sb_wins++;
                n_cmp++;
                if (streak !== STARVE_MAX) begin
                    n_bad++;
                    $display("FAIL starve_streak c%0d got=%0d want=%0d",
                             c, streak, STARVE_MAX);
                end
                streak = 0;
            end else if (iq_ready_o === 1'b1) begin
                streak++;
            end
            edge_();
        end
        n_cmp++;
        if (sb_wins !== 3) begin
            n_bad++;
            $display("FAIL starve_sb_wins got=%0d want=3", sb_wins);
        end
    endtask

    task automatic test_urgent();
        do_reset();
        iq_valid_i = 1; sb_valid_i = 1; sb_urgent_i = 1; dc_ready_i = 1;
        iq_rready_i = 1; sb_rready_i = 1;
        for (int c = 0; c < 20; c++) begin
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            dc_rvalid_i = tq.size() > 0;
            settle();
            n_cmp++;
            if ({iq_ready_o, sb_ready_o} !== 2'b01 ||
                obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL urgent c%0d got=%b want=%b",
                         c, obs_v(), exp_v());
            end
            edge_();
        end
    endtask

    task automatic test_stall();
        logic [REQ_W-1:0] held;
        do_reset();
        iq_valid_i = 1; dc_ready_i = 1;
        held = rnd_req();
        iq_req_i = held;
        settle(); edge_();
        sb_valid_i = 1; dc_ready_i = 0;
        for (int c = 0; c < 5; c++) begin
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            settle();
            n_cmp++;
            if (dc_valid_o !== 1'b1 || dc_req_o !== held ||
                {iq_ready_o, sb_ready_o} !== 2'b00) begin
                n_bad++;
                $display("FAIL stall_hold c%0d got=%h want=%h",
                         c, dc_req_o, held);
            end
            edge_();
        end
        dc_ready_i = 1;
        settle();
        n_cmp++;
        if ((iq_ready_o | sb_ready_o) !== 1'b1 ||
            obs_v() !== exp_v()) begin
            n_bad++;
            $display("FAIL stall_release got=%b want=%b", obs_v(), exp_v());
        end
        edge_();
    endtask

    task automatic test_maxout();
        do_reset();
        dc_ready_i = 1;
        for (int c = 0; c < 8; c++) begin
            iq_valid_i = (c >= 4) || (c % 2 == 0);
            sb_valid_i = (c >= 4) || (c % 2 == 1);
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            settle();
            n_cmp++;
            if (c < 4 && {iq_ready_o, sb_ready_o} !==
                         ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL maxout_grant c%0d got=%b", c,
                         {iq_ready_o, sb_ready_o});
            end else if (c >= 4 && {iq_ready_o, sb_ready_o} !== 2'b00) begin
                n_bad++;
                $display("FAIL maxout_block c%0d got=%b want=00", c,
                         {iq_ready_o, sb_ready_o});
            end
            edge_();
        end
        iq_valid_i = 0; sb_valid_i = 0;
        iq_rready_i = 1; sb_rready_i = 1;
        for (int k = 0; k < 4; k++) begin
            dc_rvalid_i = 1;
            dc_rsp_i = {$urandom, $urandom};
            settle();
            n_cmp++;
            if ({iq_rvalid_o, sb_rvalid_o} !==
                ((k % 2 == 0) ? 2'b10 : 2'b01) || rsp_o !== dc_rsp_i) begin
                n_bad++;
                $display("FAIL maxout_route k%0d got=%b", k,
                         {iq_rvalid_o, sb_rvalid_o});
            end
            edge_();
        end
        dc_rvalid_i = 0;
        settle();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL maxout_idle got=%b want=0", busy_o);
        end
        edge_();
    endtask

    task automatic test_flush();
        do_reset();
        dc_ready_i = 1;
        for (int c = 0; c < 4; c++) begin
            iq_valid_i = (c != 1);
            sb_valid_i = (c == 1);
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            settle(); edge_();
        end
        iq_valid_i = 0; sb_valid_i = 0; dc_ready_i = 0; flush = 1;
        settle();
        n_cmp++;
        if (obs_v() !== exp_v() || iq_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_cycle got=%b want=%b", obs_v(), exp_v());
        end
        edge_();
        flush = 0;
        settle();
        n_cmp++;
        if (dc_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_stage got=%b%b want=01",
                     dc_valid_o, busy_o);
        end
        edge_();
        iq_rready_i = 0; sb_rready_i = 1;
        for (int k = 0; k < 3; k++) begin
            dc_rvalid_i = 1;
            settle();
            n_cmp++;
            if ({dc_rready_o, iq_rvalid_o, sb_rvalid_o} !==
                ((k == 1) ? 3'b101 : 3'b100)) begin
                n_bad++;
                $display("FAIL flush_rsp k%0d got=%b", k,
                         {dc_rready_o, iq_rvalid_o, sb_rvalid_o});
            end
            edge_();
        end
        dc_rvalid_i = 0;
        settle();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drain got=%b want=0", busy_o);
        end
        edge_();
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        dc_ready_i = 1;
        for (int c = 0; c < 3; c++) begin
            iq_valid_i = (c != 1);
            sb_valid_i = (c == 1);
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            settle(); edge_();
        end
        iq_valid_i = 0; sb_valid_i = 0; rst_n = 0;
        settle(); edge_();
        rst_n = 1;
        settle();
        n_cmp++;
        if ({dc_valid_o, busy_o, iq_rvalid_o, sb_rvalid_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_outstanding got=%b want=0000",
                     {dc_valid_o, busy_o, iq_rvalid_o, sb_rvalid_o});
        end
        edge_();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            iq_valid_i  = $urandom_range(0, 9) < 7;
            sb_valid_i  = $urandom_range(0, 1) == 1;
            sb_urgent_i = $urandom_range(0, 9) == 0;
            flush       = $urandom_range(0, 19) == 0;
            dc_ready_i  = $urandom_range(0, 9) < 7;
            iq_rready_i = $urandom_range(0, 9) < 8;
            sb_rready_i = $urandom_range(0, 9) < 8;
            dc_rvalid_i = tq.size() > 0 && $urandom_range(0, 9) < 6;
            iq_req_i = rnd_req(); sb_req_i = rnd_req();
            dc_rsp_i = {$urandom, $urandom};
            settle();
            n_cmp++;
            if (obs_v() !== exp_v() ||
                (m_stv && dc_req_o !== m_pl) || rsp_o !== dc_rsp_i) begin
                n_bad++;
                $display("FAIL random c%0d got=%b want=%b",
                         c, obs_v(), exp_v());
            end
            edge_();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_starve();
        test_urgent();
        test_stall();
        test_maxout();
        test_flush();
        test_reset_outstanding();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_arb.md
Name: lsu_dcache_arb

Overview:
- Arbitrates the single DCache request port between two requesters: the load/store issue queue (port 0, speculative) and the committed-store drain buffer (port 1, non-speculative).
- Holds one registered output stage toward the DCache and tracks the source of every outstanding request in an in-order tag FIFO, so DCache responses route back to the right requester.
- Squashes speculative traffic on flush without losing committed stores.

Parameters:
- REQ_W, 128, width of the opaque request payload (address, wdata, strb, mask, rob id).
- RSP_W, 64, width of the opaque response payload.
- MAX_OUT, 4, maximum requests issued to the DCache but not yet answered (power of 2).
- STARVE_MAX, 8, consecutive cycles a waiting store may lose before it is forced to win.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; kills speculative (port 0) traffic
- iq_valid_i  in  1  port 0 request valid
- iq_ready_o  out  1  port 0 request accepted this cycle
- iq_req_i  in  REQ_W  port 0 payload
- sb_valid_i  in  1  port 1 (store drain) request valid
- sb_ready_o  out  1  port 1 request accepted this cycle
- sb_req_i  in  REQ_W  port 1 payload
- sb_urgent_i  in  1  store buffer nearly full; port 1 takes priority
- dc_valid_o  out  1  request to DCache valid
- dc_ready_i  in  1  DCache accepts request
- dc_req_o  out  REQ_W  request payload to DCache
- dc_rvalid_i  in  1  DCache response valid (in request order)
- dc_rready_o  out  1  arbiter accepts response
- dc_rsp_i  in  RSP_W  response payload
- iq_rvalid_o  out  1  response for port 0
- iq_rready_i  in  1  port 0 response sink ready
- sb_rvalid_o  out  1  response for port 1
- sb_rready_i  in  1  port 1 response sink ready
- rsp_o  out  RSP_W  response payload (shared by both response ports)
- busy_o  out  1  output stage or tag FIFO non-empty

Behaviour:
- Reset (rst_n=0 at a clk edge): output stage empty. dc_valid_o=0, tag FIFO empty, starve counter=0, all killed bits clear. busy_o=0, iq_rvalid_o=sb_rvalid_o=0.
- Output stage: a single register (valid, src, payload).
  - can_load = !stage_valid || dc_ready_i.
  - Grants are issued only when can_load && tag_count + (issue this cycle ? 1 : 0) - (response retired this cycle ? 1 : 0) < MAX_OUT. Credits count the stage entry plus in-flight requests.
- Arbitration, evaluated when a grant is possible:
  - Port 1 wins if sb_valid_i && (sb_urgent_i || starve_cnt == STARVE_MAX || !iq_valid_i).
  - Otherwise port 0 wins if iq_valid_i.
  - Exactly one ready is asserted, for the winner only. Latency from grant to dc_valid_o is 1 cycle.
- starve_cnt:
  - Resets to 0 when port 1 is granted or sb_valid_i=0.
  - Increments (saturating at STARVE_MAX) in each cycle where sb_valid_i=1 and port 1 is not granted.
- DCache handshake: on dc_valid_o && dc_ready_i, the stage src is pushed into the tag FIFO together with killed=0. Payload stays stable while dc_valid_o=1 && !dc_ready_i.
- Response routing:
  - The head tag selects the destination. rsp_o = dc_rsp_i.
  - If head src=0 and not killed: iq_rvalid_o = dc_rvalid_i, dc_rready_o = iq_rready_i.
  - If head src=1: sb_rvalid_o = dc_rvalid_i, dc_rready_o = sb_rready_i.
  - If head is killed: both rvalids are 0, dc_rready_o=1, and the response is dropped.
  - Pop the tag on dc_rvalid_i && dc_rready_o. dc_rvalid_i with an empty FIFO is illegal (assertion).
- Flush:
  - iq_ready_o=0 in the flush cycle.
  - If the stage holds src=0 and it is not handed off this same cycle, the stage is invalidated. Speculative requests have no side effects before DCache acceptance.
  - All tag FIFO entries with src=0, including one pushed this cycle, get killed=1.
  - Port 1 stage contents and tags are unaffected. A store may still be granted in the flush cycle.
- Simultaneous push and pop of the tag FIFO: count unchanged. Pointers wrap modulo MAX_OUT.
- busy_o = stage_valid || tag_count != 0.

Test Plan:
- Both ports valid every cycle, sb_urgent_i=0, dc_ready_i=1, STARVE_MAX=8 -> 8 consecutive port 0 grants, then 1 port 1 grant on the 9th cycle, pattern repeats; first dc_valid_o 1 cycle after first grant.
- sb_urgent_i=1 with both valid -> port 1 granted every cycle, iq_ready_o=0 throughout.
- dc_ready_i held 0 with stage full -> dc_req_o stable, both readys 0; release -> transfer, new grant the same cycle.
- Issue 4 requests (src 0,1,0,1), no responses -> 5th request blocked (MAX_OUT=4); then 4 responses -> delivered on iq, sb, iq, sb in order.
- Outstanding src 0,1,0 plus port 0 in stage, flush pulse -> stage emptied with no DCache transfer; responses 1 and 3 dropped with dc_rready_o=1 and iq_rvalid_o=0; response 2 reaches sb_rvalid_o.
- Reset asserted with 3 outstanding -> next cycle dc_valid_o=0, busy_o=0, all rvalid outputs 0.
